nibble_serial_adder_ctrl: RTL and testbench
===========================================

Name: nibble_serial_adder_ctrl

Overview:
Sequencer that adds two WIDTH-bit operands over several cycles by time-sharing one 4-bit ripple adder (four_bit_adder_bh), one nibble per cycle, LSB nibble first.
- Carry is registered between nibbles.
- Operands enter, and the result leaves, through valid/ready handshakes.
- Used wherever a wide add is needed but area matters more than latency.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4.
- NIBBLES, WIDTH/4, derived local constant; not overridable.

Ports:
- clk  input  1  single clock for all state.
- rst  input  1  reset, asynchronous and active-high.
- in_valid  input  1  operand bundle (a, b, c_in) valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- c_in  input  1  carry into nibble 0.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result a+b+c_in, modulo 2^WIDTH.
- c_out  output  1  carry out of the MSB nibble.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Clock and reset: one clock domain. Clock and reset are named clk and rst. Reset is asynchronous and active-high.
- Reset values (rst=1): state=IDLE, nibble counter=0, a_reg=b_reg=sum_reg=0, carry=0. Outputs: in_ready=1, out_valid=0, sum=0, c_out=0, busy=0.
- Reset asserted mid-operation: the operation is abandoned and produces no out_valid. The block is back in IDLE on the first edge after rst deasserts.
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready=1. On in_valid&in_ready: a_reg<=a, b_reg<=b, carry<=c_in, cnt<=0; go to RUN.
  - RUN: in_ready=0. Each cycle the adder takes a_reg[3:0], b_reg[3:0] and carry.
    - sum_reg <= {adder_sum, sum_reg[WIDTH-1:4]}.
    - a_reg and b_reg shift right by 4, zero-filled.
    - carry <= adder carry-out.
    - cnt <= cnt+1.
    - When cnt==NIBBLES-1, go to DONE.
  - DONE: out_valid=1, sum=sum_reg, c_out=carry. sum and c_out are held stable while out_ready=0. On out_ready, go to IDLE.
- Latency: if the accept handshake happens at clock edge k, out_valid rises after edge k+NIBBLES (4 cycles for WIDTH=16).
- Throughput: one operation per NIBBLES+2 cycles minimum. There is no accept in the same cycle as DONE's release.
- in_valid while in RUN or DONE is ignored. Changes on a, b and c_in after acceptance have no effect.
- sum and c_out are driven from registers only; they have no combinational path from the inputs.
- Outside DONE, sum and c_out show the current register contents and are don't-care to consumers.
- cnt is $clog2(NIBBLES) bits wide, minimum 1. For WIDTH=4, RUN lasts exactly one cycle.
- Wrap-around: the result is modulo 2^WIDTH. Overflow is reported only via c_out.

Decomposition:
- Shared package/include: state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2; NIBBLE_W=4.
- One sub-module instance: the existing four_bit_adder_bh, as the nibble datapath.
- FSM, counter and shift registers live in this module.

Test Plan:
- WIDTH=16, a=0x1234, b=0x4321, c_in=0 -> sum=0x5555, c_out=0; out_valid exactly 4 cycles after accept.
- a=0xFFFF, b=0x0001, c_in=0 -> sum=0x0000, c_out=1. Checks carry propagation through all 4 nibbles.
- a=0xFFFF, b=0x0000, c_in=1 -> sum=0x0000, c_out=1. Then a=0x8000, b=0x8000 -> sum=0x0000, c_out=1.
- Backpressure: hold out_ready=0 for 3 cycles in DONE -> out_valid, sum and c_out stable, in_ready=0. Release -> IDLE next cycle, in_ready=1.
- Pulse rst after 2 RUN cycles -> out_valid never asserts, in_ready=1 after reset. A new op 0x00FF+0x0001 -> sum=0x0100, c_out=0.
- Drive in_valid with changing a/b during RUN -> ignored; the result matches the operands captured at accept. A randomized 500-op run against a reference model passes.

Source files
------------

// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared constants and state encoding for the nibble-serial adder sequencer.
package nibble_serial_adder_ctrl_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_serial_adder_ctrl_four_bit_adder_bh.sv
// Behavioural 4-bit adder with carry in/out; the shared nibble datapath.
module four_bit_adder_bh
  import nibble_serial_adder_ctrl_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                c_in,
  output logic [NIBBLE_W-1:0] sum,
  output logic                c_out
);

  always_comb begin
    {c_out, sum} = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, c_in};
  end

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Wide adder that time-shares one 4-bit adder, LSB nibble first, with a
// registered carry between nibbles and valid/ready handshakes on both sides.
module nibble_serial_adder_ctrl
  import nibble_serial_adder_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             busy
);

  localparam int unsigned NIBBLES = WIDTH / NIBBLE_W;
  localparam int unsigned CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [WIDTH-1:0]    a_reg;
  logic [WIDTH-1:0]    b_reg;
  logic [WIDTH-1:0]    sum_reg;
  logic                carry;
  logic [NIBBLE_W-1:0] nib_sum;
  logic                nib_cout;

  four_bit_adder_bh u_nibble_adder (
    .a     (a_reg[NIBBLE_W-1:0]),
    .b     (b_reg[NIBBLE_W-1:0]),
    .c_in  (carry),
    .sum   (nib_sum),
    .c_out (nib_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      sum_reg <= '0;
      carry   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= a;
            b_reg <= b;
            carry <= c_in;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          // Shift-in from the top via a wide concat so WIDTH=4 needs no special case.
          sum_reg <= WIDTH'({nib_sum, sum_reg} >> NIBBLE_W);
          a_reg   <= a_reg >> NIBBLE_W;
          b_reg   <= b_reg >> NIBBLE_W;
          carry   <= nib_cout;
          cnt     <= cnt + 1'b1;
          if (cnt == CNT_W'(NIBBLES - 1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
    sum       = sum_reg;
    c_out     = carry;
  end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed and reference-model checks for nibble_serial_adder_ctrl at WIDTH=16.
module tb_nibble_serial_adder_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        c_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        c_out;
  logic        busy;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  nibble_serial_adder_ctrl #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+#1 with the block idle; hold = DONE cycles with out_ready low.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                        input logic [15:0] es, input logic ec,
                        input bit noise, input int unsigned hold);
    int unsigned cyc;
    check("in_ready_idle", 32'(in_ready), 32'd1);
    a = ta; b = tb_v; c_in = tc; in_valid = 1'b1;
    @(posedge clk); #1;
    if (!noise) in_valid = 1'b0;
    check("busy_run", 32'(busy), 32'd1);
    check("in_ready_run", 32'(in_ready), 32'd0);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      if (noise) begin
        a = 16'($urandom); b = 16'($urandom); c_in = 1'($urandom);
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    check("latency", cyc, 32'd4);
    check("out_valid", 32'(out_valid), 32'd1);
    check("sum", 32'(sum), 32'(es));
    check("c_out", 32'(c_out), 32'(ec));
    check("in_ready_done", 32'(in_ready), 32'd0);
    for (int unsigned i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_sum", 32'(sum), 32'(es));
      check("bp_c_out", 32'(c_out), 32'(ec));
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release_out_valid", 32'(out_valid), 32'd0);
    check("release_in_ready", 32'(in_ready), 32'd1);
    check("release_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [16:0] ref_r;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rc;
    bit          seen;

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; out_ready = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_c_out", 32'(c_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
    run_op(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 0);
    run_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
    run_op(16'h0F0F, 16'h0101, 1'b1, 16'h1011, 1'b0, 1'b0, 3);

    // Reset two cycles into RUN: the operation must vanish.
    a = 16'h1111; b = 16'h2222; c_in = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_sum", 32'(sum), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      seen = seen | out_valid;
    end
    check("midrst_no_out_valid", 32'(seen), 32'd0);
    run_op(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 0);

    // Operand churn with in_valid high during RUN/DONE must not disturb the result.
    run_op(16'hABCD, 16'h1357, 1'b1, 16'hBF25, 1'b0, 1'b1, 2);

    for (int unsigned n = 0; n < 500; n++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
      ref_r = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
      run_op(ra, rb, rc, ref_r[15:0], ref_r[16], 1'($urandom), $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
